// File: rtl/imm_ext_pkg.sv
// Mode encodings and the immediate-extension function shared by the extender datapath.
package imm_ext_pkg;

  localparam int unsigned EXT_MAX_W = 64;

  typedef enum logic [1:0] {
    MODE_SIGN = 2'b00,
    MODE_ZERO = 2'b01,
    MODE_LUI  = 2'b10,
    MODE_BR   = 2'b11
  } imm_mode_e;

  typedef logic [EXT_MAX_W-1:0] ext_word_t;

  // Works on a widest-case word; the caller keeps the low out_w bits.
  function automatic ext_word_t imm_extend(
    input ext_word_t   raw,
    input int unsigned in_w,
    input int unsigned out_w,
    input imm_mode_e   mode
  );
    ext_word_t ones;
    ext_word_t in_mask;
    ext_word_t out_mask;
    ext_word_t body;
    ext_word_t sext;
    ext_word_t res;
    logic      sign;
    ones     = '1;
    in_mask  = ~(ones << in_w);
    out_mask = ~(ones << out_w);
    body     = raw & in_mask;
    sign     = |(body & (ext_word_t'(1) << (in_w - 1)));
    sext     = sign ? (body | ~in_mask) : body;
    case (mode)
      MODE_SIGN: res = sext;
      MODE_ZERO: res = body;
      MODE_LUI:  res = body << (out_w - in_w);
      default:   res = sext << 2;
    endcase
    return res & out_mask;
  endfunction

endpackage

// File: rtl/imm_ext_fifo2.sv
// Two-entry FIFO; when empty the output keeps showing the last popped word.
module imm_ext_fifo2 #(
  parameter int unsigned W = 34
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic [W-1:0] last_q, last_d;
  logic         push;
  logic         pop;

  // Flags come from registered occupancy only, so no ready path crosses the buffer.
  assign push_ready = (count_q != 2'd2);
  assign pop_valid  = (count_q != 2'd0);
  assign push       = push_valid & push_ready;
  assign pop        = pop_valid & pop_ready;
  assign pop_data   = pop_valid ? mem_q[rd_ptr_q] : last_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    last_d   = last_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      last_d   = mem_q[rd_ptr_q];
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: rtl/imm_extender.sv
// Extends an immediate on the input side, buffers it with its mode, and counts output transfers.
module imm_extender #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_mode,
  output logic [15:0]      xfer_count
);
  import imm_ext_pkg::*;

  if (OUT_W < IN_W + 2) begin : g_bad_out_w
    $error("imm_extender: OUT_W must be at least IN_W+2");
  end
  if (OUT_W > EXT_MAX_W) begin : g_too_wide
    $error("imm_extender: OUT_W exceeds EXT_MAX_W");
  end

  ext_word_t        ext_full;
  logic [OUT_W-1:0] ext_word;
  logic [OUT_W+1:0] fifo_out;
  logic [15:0]      xfer_count_q, xfer_count_d;

  assign ext_full = imm_extend(EXT_MAX_W'(in_data), IN_W, OUT_W, imm_mode_e'(in_mode));
  assign ext_word = ext_full[OUT_W-1:0];

  if (OUT_W < EXT_MAX_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^ext_full[EXT_MAX_W-1:OUT_W];
  end

  imm_ext_fifo2 #(
    .W(OUT_W + 2)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  ({in_mode, ext_word}),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (fifo_out)
  );

  assign out_mode   = fifo_out[OUT_W+1:OUT_W];
  assign out_data   = fifo_out[OUT_W-1:0];
  assign xfer_count = xfer_count_q;

  always_comb begin
    xfer_count_d = xfer_count_q;
    if (out_valid && out_ready) begin
      xfer_count_d = xfer_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xfer_count_q <= '0;
    end else begin
      xfer_count_q <= xfer_count_d;
    end
  end

endmodule

// File: tb/tb_imm_extender.sv
// Scoreboard bench for imm_extender: accepted inputs queue their expected word, a monitor checks outputs.
module tb_imm_extender;
  localparam int unsigned IN_W  = 16;
  localparam int unsigned OUT_W = 32;

  logic             clk       = 1'b0;
  logic             reset     = 1'b1;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_data   = '0;
  logic [1:0]       in_mode   = 2'b00;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] out_data;
  logic [1:0]       out_mode;
  logic [15:0]      xfer_count;

  logic [OUT_W+1:0] cur_exp   = '0;
  logic [OUT_W+1:0] exp_q[$];
  logic [OUT_W+1:0] last_word = '0;
  logic [15:0]      exp_cnt   = '0;
  bit               rand_ready = 1'b0;
  int               checks    = 0;
  int               failures  = 0;

  logic [15:0] vec_d [8] = '{16'hFEBD, 16'hFEBD, 16'h1234, 16'hFFFF,
                             16'h8000, 16'h7FFF, 16'h4000, 16'hC000};
  logic [1:0]  vec_m [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b00, 2'b11, 2'b10};
  logic [31:0] vec_e [8] = '{32'hFFFFFEBD, 32'h0000FEBD, 32'h12340000, 32'hFFFFFFFC,
                             32'hFFFE0000, 32'h00007FFF, 32'h00010000, 32'hC0000000};

  always #5 clk = ~clk;

  imm_extender #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_mode   (out_mode),
    .xfer_count (xfer_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [OUT_W+1:0] model(input logic [15:0] d, input logic [1:0] m);
    logic [31:0] s;
    logic [31:0] r;
    s = {{16{d[15]}}, d};
    case (m)
      2'b00:   r = s;
      2'b01:   r = {16'h0000, d};
      2'b10:   r = {d, 16'h0000};
      default: r = {s[29:0], 2'b00};
    endcase
    return {m, r};
  endfunction

  // Monitor: samples on the falling edge what the next rising edge will transfer.
  always @(negedge clk) begin
    logic [OUT_W+1:0] got;
    got = {out_mode, out_data};
    chk("xfer_count", 64'(xfer_count), 64'(exp_cnt));
    chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
    if (!out_valid) chk("idle_hold", 64'(got), 64'(last_word));
    if (reset) begin
      exp_q.delete();
      exp_cnt   = '0;
      last_word = '0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%h required=none", got);
        end else begin
          last_word = exp_q.pop_front();
          chk("out_word", 64'(got), 64'(last_word));
        end
        exp_cnt++;
      end
      if (in_valid && in_ready) exp_q.push_back(cur_exp);
    end
  end

  always @(posedge clk) begin
    #2;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic [1:0] m, input logic [OUT_W+1:0] e);
    in_data  = d;
    in_mode  = m;
    cur_exp  = e;
    in_valid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready) begin
        step();
        in_valid = 1'b0;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL send_timeout actual=not_accepted required=accepted");
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (!out_valid) begin
        step();
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL drain_timeout actual=busy required=idle");
    step();
  endtask

  initial begin
    logic [15:0] base;
    logic [15:0] d;
    logic [1:0]  m;
    int          n;
    longint      t0;

    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_mode", 64'(out_mode), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    step();

    // First word: visible the cycle after acceptance, counted once popped.
    out_ready = 1'b1;
    send(16'd5323, 2'b00, {2'b00, 32'h000014CB});
    @(negedge clk);
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_data", 64'(out_data), 64'h000014CB);
    step();
    @(negedge clk);
    chk("first_count", 64'(xfer_count), 64'd1);
    step();

    for (int i = 0; i < 8; i++) send(vec_d[i], vec_m[i], {vec_m[i], vec_e[i]});
    drain();

    // Backpressure: A and B fill the buffer, C must be refused.
    out_ready = 1'b0;
    send(16'h0011, 2'b01, {2'b01, 32'h00000011});
    send(16'hF00F, 2'b00, {2'b00, 32'hFFFFF00F});
    in_data  = 16'h0C0C;
    in_mode  = 2'b10;
    cur_exp  = {2'b10, 32'h0C0C0000};
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_in_ready", 64'(in_ready), 64'd0);
      chk("stall_head", 64'({out_mode, out_data}), 64'({2'b01, 32'h00000011}));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_a", 64'({out_mode, out_data}), 64'({2'b01, 32'h00000011}));
    step();
    @(negedge clk);
    chk("release_b", 64'({out_mode, out_data}), 64'({2'b00, 32'hFFFFF00F}));
    step();
    drain();

    base = exp_cnt;
    rand_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      d = 16'($urandom);
      m = 2'($urandom_range(0, 3));
      send(d, m, model(d, m));
    end
    drain();
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    drain();
    @(negedge clk);
    chk("stream_count", 64'(xfer_count), 64'(base + 16'd100));
    step();

    // Reset with two words buffered.
    out_ready = 1'b0;
    send(16'h0001, 2'b00, {2'b00, 32'h00000001});
    send(16'h0002, 2'b01, {2'b01, 32'h00000002});
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst2_valid", 64'(out_valid), 64'd0);
    chk("rst2_count", 64'(xfer_count), 64'd0);
    chk("rst2_data", 64'(out_data), 64'd0);
    step();
    out_ready = 1'b1;
    send(16'h00AA, 2'b01, {2'b01, 32'h000000AA});
    drain();
    @(negedge clk);
    chk("after_rst_count", 64'(xfer_count), 64'd1);
    step();

    // Input offered in the reset cycle must be dropped.
    out_ready = 1'b0;
    send(16'h0003, 2'b00, {2'b00, 32'h00000003});
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h0BAD;
    in_mode  = 2'b00;
    cur_exp  = {2'b00, 32'h00000BAD};
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("rst3_count", 64'(xfer_count), 64'd0);
    chk("rst3_valid", 64'(out_valid), 64'd0);
    step();

    // Wrap of the transfer counter at full streaming rate.
    n  = 65536 - int'(exp_cnt);
    t0 = longint'($time);
    for (int i = 0; i < n - 1; i++) begin
      d = 16'(i);
      m = 2'(i);
      send(d, m, model(d, m));
    end
    chk("throughput_cycles", 64'((longint'($time) - t0) / 10), 64'(n - 1));
    drain();
    @(negedge clk);
    chk("count_ffff", 64'(xfer_count), 64'hFFFF);
    step();
    send(16'hABCD, 2'b01, {2'b01, 32'h0000ABCD});
    drain();
    @(negedge clk);
    chk("count_wrap", 64'(xfer_count), 64'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
